romulus_control: RTL and testbench

- Sequencing FSM for the Romulus datapath: accepts one command at a time and drives that datapath's reset, enable and mode strobes.
- Also generates the SKINNY round constant, the domain byte and the per-byte decrypt mask.
- Sits between the host-side command/stream interface and the datapath.
- Runs one SKINNY round per cycle, then one tweakey-correction cycle per block.

---
 rtl/romulus_pkg.sv | 35 +++
 rtl/romulus_rc_lfsr.sv | 29 ++
 rtl/romulus_control.sv | 198 +++++++++++++++++++
 tb/tb_romulus_control.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_pkg.sv
// Shared encodings for the Romulus sequencing controller and its round-constant LFSR.
package romulus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_TWEAK   = 3'd2,
    ST_ABSORB  = 3'd3,
    ST_ROUND   = 3'd4,
    ST_CORRECT = 3'd5,
    ST_TAG     = 3'd6
  } state_t;

  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_TWEAK = 2'b01;
  localparam logic [1:0] OP_BLOCK = 2'b10;
  localparam logic [1:0] OP_TAG   = 2'b11;

  localparam logic [5:0] RC_INIT        = 6'h01;
  localparam int         ROUNDS_DEFAULT = 40;

  typedef struct packed {
    logic srst; logic sen; logic senc;
    logic xrst; logic xen; logic xenc;
    logic yrst; logic yen; logic yenc;
    logic zrst; logic zen; logic zenc;
    logic erst; logic correct_cnt; logic tk1s;
  } strobes_t;

  // SKINNY places rc[5:4] in row 1 and rc[3:0] in row 0 of the constant word
  function automatic logic [11:0] rc_to_constant(input logic [5:0] rc);
    return {2'b00, rc[5:4], 4'b0000, rc[3:0]};
  endfunction

endpackage

// File: rtl/romulus_rc_lfsr.sv
// 6-bit SKINNY round-constant LFSR with re-seed (load) and advance (step) controls.
module romulus_rc_lfsr
  import romulus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [5:0] rc
);

  logic [5:0] rc_r;

  // Constant state: load has priority so a block can re-seed on its absorb cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_r <= RC_INIT;
    end else if (load) begin
      rc_r <= RC_INIT;
    end else if (step) begin
      rc_r <= {rc_r[4:0], rc_r[5] ^ rc_r[4] ^ 1'b1};
    end else begin
      rc_r <= rc_r;
    end
  end

  assign rc = rc_r;

endmodule

// File: rtl/romulus_control.sv
// Romulus datapath sequencer: command FSM, strobe decode, round constant and decrypt mask.
// Optional decryption support is enabled by defining ROMULUS_DECRYPT_EN.
module romulus_control
  import romulus_pkg::*;
#(
  parameter int BUSWIDTH      = 128,
  parameter int ROUNDS        = ROUNDS_DEFAULT,
  parameter int CONSTANTWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_domain,
  input  logic                     cmd_decrypt,
  output logic                     pdo_valid,
  input  logic                     pdo_ready,
  output logic                     done,
  output logic                     srst,
  output logic                     sen,
  output logic                     senc,
  output logic                     xrst,
  output logic                     xen,
  output logic                     xenc,
  output logic                     yrst,
  output logic                     yen,
  output logic                     yenc,
  output logic                     zrst,
  output logic                     zen,
  output logic                     zenc,
  output logic                     erst,
  output logic                     correct_cnt,
  output logic                     tk1s,
  output logic [CONSTANTWIDTH-1:0] constant,
  output logic [7:0]               domain,
  output logic [BUSWIDTH/8-1:0]    decrypt
);

  localparam int CW = $clog2(ROUNDS) + 1;
  localparam int NB = BUSWIDTH / 8;

  state_t          state_r, state_s;
  logic [CW-1:0]   round_r;
  logic [7:0]      domain_r;
  logic [5:0]      rc_s;
  strobes_t        stb_s;
  logic            ready_s, pv_s, done_s, dec_on_s, accept_s, rc_load_s, rc_step_s;
  logic            dec_bit_s;

  romulus_rc_lfsr u_rc (
    .clk  (clk),
    .rst  (rst),
    .load (rc_load_s),
    .step (rc_step_s),
    .rc   (rc_s)
  );

  // Next-state and strobe decode
  always_comb begin
    state_s   = state_r;
    stb_s     = '0;
    ready_s   = 1'b0;
    pv_s      = 1'b0;
    done_s    = 1'b0;
    dec_on_s  = 1'b0;
    accept_s  = 1'b0;
    rc_load_s = 1'b0;
    rc_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        if (cmd_valid) begin
          accept_s = 1'b1;
          case (cmd_op)
            OP_INIT:  state_s = ST_INIT;
            OP_TWEAK: state_s = ST_TWEAK;
            OP_BLOCK: state_s = ST_ABSORB;
            OP_TAG:   state_s = ST_TAG;
            default:  state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        stb_s.srst = 1'b1;
        stb_s.xrst = 1'b1;
        stb_s.zrst = 1'b1;
        stb_s.erst = 1'b1;
        done_s     = 1'b1;
        state_s    = ST_IDLE;
      end
      ST_TWEAK: begin
        stb_s.yrst = 1'b1;
        done_s     = 1'b1;
        state_s    = ST_IDLE;
      end
      ST_ABSORB: begin
        pv_s     = 1'b1;
        dec_on_s = 1'b1;
        if (pdo_ready) begin
          stb_s.sen = 1'b1;
          rc_load_s = 1'b1;
          state_s   = ST_ROUND;
        end else begin
          state_s   = ST_ABSORB;
        end
      end
      ST_ROUND: begin
        stb_s.sen  = 1'b1; stb_s.senc = 1'b1;
        stb_s.xen  = 1'b1; stb_s.xenc = 1'b1;
        stb_s.yen  = 1'b1; stb_s.yenc = 1'b1;
        stb_s.zen  = 1'b1; stb_s.zenc = 1'b1;
        rc_step_s  = 1'b1;
        if (round_r == CW'(ROUNDS - 1)) begin
          state_s = ST_CORRECT;
        end else begin
          state_s = ST_ROUND;
        end
      end
      ST_CORRECT: begin
        stb_s.xen         = 1'b1;
        stb_s.yen         = 1'b1;
        stb_s.zen         = 1'b1;
        stb_s.correct_cnt = 1'b1;
        stb_s.tk1s        = 1'b1;
        done_s            = 1'b1;
        state_s           = ST_IDLE;
      end
      ST_TAG: begin
        pv_s = 1'b1;
        if (pdo_ready) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_TAG;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, round counter and captured domain byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      round_r  <= '0;
      domain_r <= 8'h00;
    end else begin
      state_r <= state_s;
      if (rc_load_s) begin
        round_r <= '0;
      end else if (state_r == ST_ROUND) begin
        round_r <= round_r + CW'(1);
      end else begin
        round_r <= round_r;
      end
      if (accept_s) begin
        domain_r <= cmd_domain;
      end else begin
        domain_r <= domain_r;
      end
    end
  end

`ifdef ROMULUS_DECRYPT_EN
  logic dec_r;

  // Decrypt flag captured with the command
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_r <= 1'b0;
    end else if (accept_s) begin
      dec_r <= cmd_decrypt;
    end else begin
      dec_r <= dec_r;
    end
  end

  assign dec_bit_s = dec_r;
`else
  logic unused_decrypt_s;
  assign unused_decrypt_s = cmd_decrypt;
  assign dec_bit_s        = 1'b0;
`endif

  // Outputs are forced low for the whole reset cycle, not just after it
  assign {srst, sen, senc, xrst, xen, xenc, yrst, yen, yenc,
          zrst, zen, zenc, erst, correct_cnt, tk1s} = rst ? 15'b0 : stb_s;
  assign cmd_ready = ready_s & ~rst;
  assign pdo_valid = pv_s & ~rst;
  assign done      = done_s & ~rst;
  assign domain    = rst ? 8'h00 : domain_r;
  assign constant  = (!rst && state_r == ST_ROUND) ? CONSTANTWIDTH'(rc_to_constant(rc_s)) : '0;
  assign decrypt   = (!rst && dec_on_s) ? {NB{dec_bit_s}} : '0;

endmodule

// File: tb/tb_romulus_control.sv
// Directed table-driven bench for romulus_control (default parameters, either decrypt build).
module tb_romulus_control;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_decrypt, pdo_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_domain;
  logic        cmd_ready, pdo_valid, done;
  logic        srst, sen, senc, xrst, xen, xenc, yrst, yen, yenc, zrst, zen, zenc;
  logic        erst, correct_cnt, tk1s;
  logic [11:0] constant;
  logic [7:0]  domain;
  logic [15:0] decrypt;

  romulus_control dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_domain(cmd_domain), .cmd_decrypt(cmd_decrypt),
    .pdo_valid(pdo_valid), .pdo_ready(pdo_ready), .done(done),
    .srst(srst), .sen(sen), .senc(senc), .xrst(xrst), .xen(xen), .xenc(xenc),
    .yrst(yrst), .yen(yen), .yenc(yenc), .zrst(zrst), .zen(zen), .zenc(zenc),
    .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s),
    .constant(constant), .domain(domain), .decrypt(decrypt)
  );

  always #5 clk = ~clk;

  wire [14:0] stb = {srst, sen, senc, xrst, xen, xenc, yrst, yen, yenc,
                     zrst, zen, zenc, erst, correct_cnt, tk1s};

  localparam logic [14:0] S_NONE   = 15'b000_000_000_000_000;
  localparam logic [14:0] S_INIT   = 15'b100_100_000_100_100;
  localparam logic [14:0] S_TWEAK  = 15'b000_000_100_000_000;
  localparam logic [14:0] S_ABSORB = 15'b010_000_000_000_000;
`ifdef ROMULUS_DECRYPT_EN
  localparam logic [15:0] DEC_ON = 16'hFFFF;
`else
  localparam logic [15:0] DEC_ON = 16'h0000;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  dom;
    logic        dec;
    int          stall;
    logic [14:0] exp_stb;
    logic        exp_pv;
    logic [15:0] exp_dec;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] dom, input logic dec);
    cmd_op = op; cmd_domain = dom; cmd_decrypt = dec; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    chk(name, {31'b0, done}, 32'd1);
    tick();
  endtask

  initial begin
    logic [11:0] cexp[6];
    int cyc, scnt, ycnt, dcnt;
    logic got;

    cexp = '{12'h001, 12'h003, 12'h007, 12'h00F, 12'h10F, 12'h30E};
    vecs[0] = '{OP_INIT_V(), 8'h11, 1'b0, 0, S_INIT,   1'b0, 16'h0000, 1};
    vecs[1] = '{2'b01,       8'h22, 1'b0, 0, S_TWEAK,  1'b0, 16'h0000, 1};
    vecs[2] = '{2'b10,       8'h33, 1'b0, 0, S_ABSORB, 1'b1, 16'h0000, 42};
    vecs[3] = '{2'b10,       8'h44, 1'b1, 0, S_ABSORB, 1'b1, DEC_ON,   42};
    vecs[4] = '{2'b10,       8'h55, 1'b1, 5, S_NONE,   1'b1, DEC_ON,   47};
    vecs[5] = '{2'b11,       8'h66, 1'b0, 0, S_NONE,   1'b1, 16'h0000, 1};
    vecs[6] = '{2'b11,       8'h77, 1'b0, 3, S_NONE,   1'b1, 16'h0000, 4};

    // reset: everything low, even with a command presented
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_domain = 8'hEE;
    cmd_decrypt = 1'b1; pdo_ready = 1'b1;
    tick(); tick();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_strobes", {17'b0, stb}, 32'd0);
    chk("rst_domain", {24'b0, domain}, 32'd0);
    chk("rst_pv_done", {30'b0, pdo_valid, done}, 32'd0);
    cmd_valid = 1'b0; rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

    // table of single commands: first-cycle decode and accept-to-done latency
    for (int i = 0; i < 7; i++) begin
      pdo_ready = (vecs[i].stall == 0);
      issue(vecs[i].op, vecs[i].dom, vecs[i].dec);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
        cyc++;
        pdo_ready = (cyc > vecs[i].stall);
        #1;
        if (cyc == 1) begin
          chk("vec_strobes", {17'b0, stb}, {17'b0, vecs[i].exp_stb});
          chk("vec_pdo_valid", {31'b0, pdo_valid}, {31'b0, vecs[i].exp_pv});
          chk("vec_decrypt", {16'b0, decrypt}, {16'b0, vecs[i].exp_dec});
          chk("vec_domain", {24'b0, domain}, {24'b0, vecs[i].dom});
        end
        if (done) begin
          got = 1'b1;
          chk("vec_ready_in_done", {31'b0, cmd_ready}, 32'd0);
        end
        tick();
      end
      chk("vec_latency", cyc, vecs[i].exp_lat);
      chk("vec_ready_after_done", {31'b0, cmd_ready}, 32'd1);
      pdo_ready = 1'b0;
    end

    // full block: constant sequence, 40 round cycles, correction cycle
    pdo_ready = 1'b1;
    issue(2'b10, 8'hA5, 1'b0);
    #1;
    chk("blk_absorb_sen_senc", {30'b0, sen, senc}, 32'b10);
    tick();
    scnt = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      #1;
      if (senc) scnt++;
      if (cyc < 6) chk("blk_constant", {20'b0, constant}, {20'b0, cexp[cyc]});
      if (done) begin
        got = 1'b1;
        chk("blk_correct", {29'b0, correct_cnt, tk1s, senc}, 32'b110);
        chk("blk_const_correct", {20'b0, constant}, 32'd0);
      end
      cyc++;
      tick();
    end
    chk("blk_round_count", scnt, 40);

    // backpressure in absorb
    pdo_ready = 1'b0;
    issue(2'b10, 8'h3C, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold", {29'b0, pdo_valid, sen, |constant}, 32'b100);
      tick();
    end
    pdo_ready = 1'b1;
    #1;
    chk("bp_release_sen", {31'b0, sen}, 32'd1);
    chk("bp_decrypt_absorb", {16'b0, decrypt}, {16'b0, DEC_ON});
    tick();
    #1;
    chk("bp_first_round_const", {20'b0, constant}, 32'h001);
    chk("bp_decrypt_round", {16'b0, decrypt}, 32'd0);
    wait_done("bp_done");

    // reset during round 17 abandons the block
    issue(2'b10, 8'h99, 1'b0);
    tick();
    for (int k = 0; k < 17; k++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_strobes", {17'b0, stb}, 32'd0);
    chk("midrst_done_ready", {30'b0, done, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 45; k++) begin
      #1;
      if (done) dcnt++;
      tick();
    end
    chk("midrst_no_done", dcnt, 0);
    chk("midrst_idle", {16'b0, cmd_ready, stb}, {16'b0, 1'b1, 15'b0});
    issue(2'b10, 8'h12, 1'b0);
    tick();
    #1;
    chk("midrst_restart_const", {20'b0, constant}, 32'h001);
    wait_done("midrst_restart_done");

    // TAG then TWEAK back to back
    issue(2'b11, 8'hC3, 1'b0);
    #1;
    chk("tag_sen_done_pv", {29'b0, sen, done, pdo_valid}, 32'b011);
    tick();
    issue(2'b01, 8'h5A, 1'b0);
    ycnt = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (yrst) ycnt++;
      tick();
    end
    chk("tweak_yrst_once", ycnt, 1);
    chk("tweak_domain", {24'b0, domain}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [1:0] OP_INIT_V();
    return 2'b00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
